mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Parametrised byte-bus memory controller: arbitrates NUM_PORTS requesters (i-fetch, load/store, future second fetch path) onto the single 8-bit RAM/IO bus.
- Replaces the fixed two-client serializer.
- Adds N-port round-robin arbitration, 1/2/4-byte little-endian transfers, per-port read flush (branch mispredict kill) and rdy_in-safe write gating.
- Sits between the execute/fetch units and the top-level mem_* pins.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8).
- PTR_W, 3, width of round-robin pointer; must satisfy 2**PTR_W >= NUM_PORTS.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  global ready; low freezes the controller.
- req_valid  in  NUM_PORTS  per-port request; held until accepted.
- req_write  in  NUM_PORTS  1 = store, 0 = load.
- req_addr  in  NUM_PORTS*32  byte address; port p at [32p+31:32p].
- req_size  in  NUM_PORTS*2  00 byte, 01 half, 1x word.
- req_wdata  in  NUM_PORTS*32  store data, little-endian.
- flush_in  in  NUM_PORTS  kill in-flight read of that port.
- req_ready  out  NUM_PORTS  one-hot accept strobe (combinational).
- resp_valid  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- resp_rdata  out  32  load data, zero-extended; shared by all ports.
- mem_din  in  8  RAM/IO read byte.
- mem_dout  out  8  RAM/IO write byte.
- mem_a  out  32  bus address.
- mem_wr  out  1  1 = write.

Behaviour:
- Reset (async, immediate): state IDLE, rr pointer 0, mem_a 0, mem_dout 0, mem_wr 0, resp_valid 0, resp_rdata 0, byte counter 0.
- Bus contract: the byte addressed by mem_a, driven after edge E, is sampled from mem_din at edge E+1. A write takes effect in any cycle where mem_wr = 1.
- States: IDLE, READ, WRITE.
- IDLE:
  - Grant g = first p with req_valid[p], scanning from the rr pointer upward with wrap.
  - req_ready[g] = 1 only when rdy_in = 1. req_ready = 0 in every other state.
  - At the accept edge:
    - Latch addr, size n (1/2/4), wdata and owner.
    - Set mem_a = addr and counter = 0.
    - For a write: mem_dout = wdata[7:0], internal wr flag set.
    - rr pointer becomes g+1 mod NUM_PORTS.
- READ, edge with counter = i:
  - Capture mem_din into byte i; counter i+1.
  - If i+1 < n: mem_a = addr+i+1 (32-bit wrap; misaligned allowed).
  - Else: resp_rdata = assembled bytes, upper unused bytes 0; resp_valid[owner] = 1; mem_a = 0; go to IDLE.
  - Latency: resp_valid high exactly n cycles after the accept edge (no stalls).
- WRITE, edge with counter = i:
  - If i+1 < n: mem_a = addr+i+1, mem_dout = byte i+1.
  - Else: clear wr flag, mem_a = 0, resp_valid[owner] = 1, go to IDLE. Latency is n cycles.
- mem_wr = wr flag AND rdy_in. Each byte is written exactly once.
- resp_valid is a one-cycle pulse. resp_rdata holds its value until the next read completes; writes do not change it.
- A new request may be accepted in the same cycle resp_valid is high (zero-bubble back-to-back).
- rdy_in low:
  - No state, counter, pointer or output register changes. mem_a is held, so the pending read byte remains valid.
  - resp_valid is held.
  - Combinational req_ready = 0 and mem_wr = 0.
- flush_in[owner] = 1 during READ (with rdy_in = 1):
  - Next edge: go to IDLE, mem_a = 0, no resp_valid, resp_rdata unchanged.
  - Flush beats completion in the same cycle.
- Flush during WRITE, or of a non-owner port: ignored. Stores always complete.
- IO region (addr[17:16] = 11) is accessed exactly once per requested byte; no speculative or prefetch reads are ever issued.

Test Plan:
- Word load, port 0, addr 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles; resp_valid[0] 4 cycles after accept; resp_rdata 0x44332211.
- Half store, port 1, addr 0x202, wdata 0xAABBCCDD -> mem_wr high 2 cycles: (0x202, DD) then (0x203, CC); resp_valid[1]; resp_rdata unchanged.
- NUM_PORTS = 3, all ports requesting continuously -> grants in order 0, 1, 2, 0, 1 with no idle cycle between transactions.
- Byte read from 0x30000 with rdy_in low for 3 cycles mid-transfer -> 0x30000 issued once; mem_wr stays 0; result correct; latency 1+3 cycles.
- Word load on port 0 with flush_in[0] pulsed after byte 1 -> IDLE next edge; no resp_valid; the next queued request is accepted immediately.
- rst_in asserted mid-write at counter = 1 -> all outputs 0 immediately; no further mem_wr pulses.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: N-port round-robin byte-bus memory controller.
// Serialises 1/2/4-byte little-endian loads and stores from NUM_PORTS
// requesters onto a single 8-bit RAM/IO bus. Supports per-port read
// flush and a global rdy_in freeze.
module mem_ctrl #(
   parameter int NUM_PORTS = 2,
   parameter int PTR_W     = 3
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic [NUM_PORTS-1:0]   req_valid,
   input  logic [NUM_PORTS-1:0]   req_write,
   input  logic [NUM_PORTS*32-1:0] req_addr,
   input  logic [NUM_PORTS*2-1:0] req_size,
   input  logic [NUM_PORTS*32-1:0] req_wdata,
   input  logic [NUM_PORTS-1:0]   flush_in,
   output logic [NUM_PORTS-1:0]   req_ready,
   output logic [NUM_PORTS-1:0]   resp_valid,
   output logic [31:0]            resp_rdata,
   input  logic [7:0]             mem_din,
   output logic [7:0]             mem_dout,
   output logic [31:0]            mem_a,
   output logic                   mem_wr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t               state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
   logic [31:0]          rbuf;
   logic [1:0]           last_q;   // index of final byte (0, 1 or 3)
   logic [1:0]           cnt;
   logic [NUM_PORTS-1:0] own_oh;   // owner of the in-flight transfer
   logic                 wr_flag;

   logic                 gnt_any, hi_any;
   logic [PTR_W-1:0]     gnt_idx, hi_idx, lo_idx, rr_nxt;
   logic [31:0]          sel_addr, sel_wdata;
   logic [1:0]           sel_size, sel_last;
   logic                 sel_write;
   logic [31:0]          rd_asm, nxt_a;
   logic [1:0]           nxt_cnt;
   logic [7:0]           wbyte;

   // Round-robin grant: lowest requester at or above rr_ptr, else lowest overall
   always_comb begin
      gnt_any = 1'b0;
      hi_any  = 1'b0;
      hi_idx  = '0;
      lo_idx  = '0;
      for (int p = NUM_PORTS-1; p >= 0; p--) begin
         if (req_valid[p]) begin
            gnt_any = 1'b1;
            lo_idx  = PTR_W'(p);
            if (PTR_W'(p) >= rr_ptr) begin
               hi_any = 1'b1;
               hi_idx = PTR_W'(p);
            end
         end
      end
      gnt_idx = hi_any ? hi_idx : lo_idx;
      rr_nxt  = (gnt_idx == PTR_W'(NUM_PORTS-1)) ? '0 : gnt_idx + PTR_W'(1);
   end

   // Accept strobe and mux of the granted port's request fields
   always_comb begin
      req_ready = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_size  = '0;
      sel_write = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_idx == PTR_W'(p)) begin
            req_ready[p] = (state == IDLE) && rdy_in && gnt_any;
            sel_addr     = req_addr[32*p +: 32];
            sel_wdata    = req_wdata[32*p +: 32];
            sel_size     = req_size[2*p +: 2];
            sel_write    = req_write[p];
         end
      end
      case (sel_size)
         2'b00:   sel_last = 2'd0;
         2'b01:   sel_last = 2'd1;
         default: sel_last = 2'd3;
      endcase
   end

   // Per-beat datapath: next address, next store byte, assembled load word
   always_comb begin
      nxt_cnt = cnt + 2'd1;
      nxt_a   = addr_q + 32'(nxt_cnt);
      wbyte   = wdata_q[{nxt_cnt, 3'b000} +: 8];
      rd_asm  = rbuf;
      rd_asm[{cnt, 3'b000} +: 8] = mem_din;
   end

   // Writes only strobe while the system is running, so a frozen cycle never
   // double-writes a byte.
   assign mem_wr = wr_flag & rdy_in;

   // Controller FSM; every register holds while rdy_in is low
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rbuf       <= '0;
         last_q     <= '0;
         cnt        <= '0;
         own_oh     <= '0;
         wr_flag    <= 1'b0;
         mem_a      <= '0;
         mem_dout   <= '0;
         resp_valid <= '0;
         resp_rdata <= '0;
      end else if (rdy_in) begin
         resp_valid <= '0;
         case (state)
            IDLE: if (gnt_any) begin
               addr_q  <= sel_addr;
               wdata_q <= sel_wdata;
               last_q  <= sel_last;
               own_oh  <= req_ready;
               cnt     <= '0;
               rbuf    <= '0;
               mem_a   <= sel_addr;
               rr_ptr  <= rr_nxt;
               if (sel_write) begin
                  mem_dout <= sel_wdata[7:0];
                  wr_flag  <= 1'b1;
                  state    <= WRITE;
               end else begin
                  state    <= READ;
               end
            end
            READ: if (|(flush_in & own_oh)) begin
               // kill wins over completion; result register untouched
               mem_a <= '0;
               state <= IDLE;
            end else begin
               rbuf <= rd_asm;
               cnt  <= nxt_cnt;
               if (cnt != last_q) begin
                  mem_a <= nxt_a;
               end else begin
                  resp_rdata <= rd_asm;
                  resp_valid <= own_oh;
                  mem_a      <= '0;
                  state      <= IDLE;
               end
            end
            WRITE: if (cnt != last_q) begin
               mem_a    <= nxt_a;
               mem_dout <= wbyte;
               cnt      <= nxt_cnt;
            end else begin
               wr_flag    <= 1'b0;
               mem_a      <= '0;
               resp_valid <= own_oh;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
